// File: rtl/dallanma_ongorucu.sv
// dallanma_ongorucu -- branch predictor beside fetch.
//
// A direct-mapped BTB supplies the predicted target and a table of 2-bit
// saturating counters supplies the direction. The lookup is purely
// combinational from registered tables, so the prediction comes back in the
// same cycle as the fetch PC. The tables are trained from the resolution
// unit's update port. A speculative global history is kept alongside a
// committed history, and the speculative copy is repaired on a misprediction.
//
// Optional feature: define ONGORUCU_GSHARE_EN to index the counter table with
// (branch index XOR global history), i.e. gshare. When it is undefined the
// predictor is bimodal; both histories still run and are visible on gecmis_o.
//
// Handshake: there is no back-pressure. ps_gecerli_i qualifies ps_i in the
// cycle it is high and a lookup is accepted every cycle; guncelle_gecerli_i
// qualifies all guncelle_* inputs and dallanma_hata_i in the cycle it is
// high, and the update takes effect at that rising edge.
//
// Ports:
//   clk_i                    clock, rising edge
//   rst_i                    synchronous active-high reset
//   ps_i, ps_gecerli_i       fetch PC and its valid
//   atlar_o                  predicted taken
//   ongoru_hedef_o           predicted target, 0 when not predicted taken
//   guncelle_gecerli_i       resolved-branch update valid
//   guncelle_atladi_i        resolved branch was taken
//   guncelle_ps_i            PC of the resolved branch
//   guncelle_hedef_adresi_i  resolved next PC (BTB target)
//   dallanma_hata_i          resolved branch was mispredicted
//   gecmis_o                 speculative global history (debug)

module dallanma_ongorucu #(
    parameter int TABLO_BOYUT = 64,
    parameter int GECMIS_BIT  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           ps_i,
    input  logic                  ps_gecerli_i,
    output logic                  atlar_o,
    output logic [31:0]           ongoru_hedef_o,
    input  logic                  guncelle_gecerli_i,
    input  logic                  guncelle_atladi_i,
    input  logic [31:0]           guncelle_ps_i,
    input  logic [31:0]           guncelle_hedef_adresi_i,
    input  logic                  dallanma_hata_i,
    output logic [GECMIS_BIT-1:0] gecmis_o
);

    localparam int IDX   = $clog2(TABLO_BOYUT);
    localparam int TAG_W = 31 - IDX;

    // Table state
    logic [TABLO_BOYUT-1:0] gecerli_q;
    logic [TAG_W-1:0]       etiket_q [TABLO_BOYUT];
    logic [31:0]            hedef_q  [TABLO_BOYUT];
    logic [1:0]             sayac_q  [TABLO_BOYUT];

    logic [GECMIS_BIT-1:0]  gecmis_spek_q;
    logic [GECMIS_BIT-1:0]  gecmis_kesin_q;

    // Lookup-side and update-side index/tag. PCs are 2-byte aligned, so
    // bit 0 never takes part.
    logic [IDX-1:0]   bi, ci;
    logic [TAG_W-1:0] tag;
    logic [IDX-1:0]   gbi, gci;
    logic [TAG_W-1:0] gtag;

    assign bi   = ps_i[IDX:1];
    assign tag  = ps_i[31:IDX+1];
    assign gbi  = guncelle_ps_i[IDX:1];
    assign gtag = guncelle_ps_i[31:IDX+1];

`ifdef ONGORUCU_GSHARE_EN
    // Prediction hashes with the speculative history; training hashes with
    // the committed history as it stood before this update shifts it.
    assign ci  = bi  ^ IDX'(gecmis_spek_q);
    assign gci = gbi ^ IDX'(gecmis_kesin_q);
`else
    assign ci  = bi;
    assign gci = gbi;
`endif

    logic unused_lsb;
    assign unused_lsb = ^{ps_i[0], guncelle_ps_i[0]};

    // Same-cycle lookup; a write in this cycle is only seen after the edge.
    logic isabet;
    logic atlar;

    assign isabet         = ps_gecerli_i && gecerli_q[bi] && (etiket_q[bi] == tag);
    assign atlar          = isabet && sayac_q[ci][1];
    assign atlar_o        = atlar;
    assign ongoru_hedef_o = atlar ? hedef_q[bi] : 32'd0;
    assign gecmis_o       = gecmis_spek_q;

    // Committed history after absorbing the current resolved outcome; also
    // the value the speculative history is repaired to.
    logic [GECMIS_BIT-1:0] yeni_kesin;
    assign yeni_kesin = {gecmis_kesin_q[GECMIS_BIT-2:0], guncelle_atladi_i};

    // Valid bits, counters and histories: reset and trained here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_q      <= '0;
            gecmis_spek_q  <= '0;
            gecmis_kesin_q <= '0;
            for (int i = 0; i < TABLO_BOYUT; i++) begin
                sayac_q[i] <= 2'b01;
            end
        end else begin
            if (guncelle_gecerli_i) begin
                if (guncelle_atladi_i) begin
                    gecerli_q[gbi] <= 1'b1;
                    if (sayac_q[gci] != 2'b11) begin
                        sayac_q[gci] <= sayac_q[gci] + 2'd1;
                    end
                end else if (sayac_q[gci] != 2'b00) begin
                    sayac_q[gci] <= sayac_q[gci] - 2'd1;
                end
                gecmis_kesin_q <= yeni_kesin;
            end

            // Repair wins over the speculative shift of a concurrent hit.
            if (dallanma_hata_i && guncelle_gecerli_i) begin
                gecmis_spek_q <= yeni_kesin;
            end else if (isabet) begin
                gecmis_spek_q <= {gecmis_spek_q[GECMIS_BIT-2:0], atlar};
            end
        end
    end

    // Tag and target storage carries no reset: a cleared valid bit hides it.
    // Not-taken outcomes never touch the BTB.
    always_ff @(posedge clk_i) begin
        if (!rst_i && guncelle_gecerli_i && guncelle_atladi_i) begin
            etiket_q[gbi] <= gtag;
            hedef_q[gbi]  <= guncelle_hedef_adresi_i;
        end
    end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Directed bench for dallanma_ongorucu (default build: 64 entries, bimodal).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled before the next rising edge.

module tb_dallanma_ongorucu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ps;
    logic        ps_gecerli;
    logic        atlar;
    logic [31:0] ongoru_hedef;
    logic        guncelle_gecerli;
    logic        guncelle_atladi;
    logic [31:0] guncelle_ps;
    logic [31:0] guncelle_hedef_adresi;
    logic        dallanma_hata;
    logic [5:0]  gecmis;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    dallanma_ongorucu #(.TABLO_BOYUT(64), .GECMIS_BIT(6)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .ps_i                   (ps),
        .ps_gecerli_i           (ps_gecerli),
        .atlar_o                (atlar),
        .ongoru_hedef_o         (ongoru_hedef),
        .guncelle_gecerli_i     (guncelle_gecerli),
        .guncelle_atladi_i      (guncelle_atladi),
        .guncelle_ps_i          (guncelle_ps),
        .guncelle_hedef_adresi_i(guncelle_hedef_adresi),
        .dallanma_hata_i        (dallanma_hata),
        .gecmis_o               (gecmis)
    );

    // Scoreboard: expected value queued, then compared against the DUT.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        logic [31:0] e;
        exp_q.push_back(expv);
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, e);
        end
    endtask

    // Driver tasks
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Lookup without letting it reach an edge, so history is not disturbed.
    task automatic peek(input string tag, input logic [31:0] pc,
                        input logic exp_atlar, input logic [31:0] exp_hedef);
        ps         = pc;
        ps_gecerli = 1'b1;
        #1;
        check({tag, "_atlar"}, {31'd0, atlar}, {31'd0, exp_atlar});
        check({tag, "_hedef"}, ongoru_hedef, exp_hedef);
        ps_gecerli = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken,
                         input logic [31:0] target, input logic hata);
        guncelle_gecerli      = 1'b1;
        guncelle_atladi       = taken;
        guncelle_ps           = pc;
        guncelle_hedef_adresi = target;
        dallanma_hata         = hata;
        clk_step();
        guncelle_gecerli      = 1'b0;
        guncelle_atladi       = 1'b0;
        dallanma_hata         = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ps = 32'd0; ps_gecerli = 1'b0;
        guncelle_gecerli = 1'b0; guncelle_atladi = 1'b0;
        guncelle_ps = 32'd0; guncelle_hedef_adresi = 32'd0; dallanma_hata = 1'b0;

        // Reset behaviour
        repeat (2) clk_step();
        rst = 1'b0;
        peek("rst", 32'h100, 1'b0, 32'h0);
        check("rst_gecmis", {26'd0, gecmis}, 32'h0);

        // Single taken update: counter 01->10, committed history 000001
        train(32'h100, 1'b1, 32'h80, 1'b0);
        peek("tek_hit", 32'h100, 1'b1, 32'h80);
        peek("tek_alias", 32'h180, 1'b0, 32'h0);

        // Hysteresis / saturation: 4 taken -> 11, then not-taken -> 10
        repeat (4) train(32'h100, 1'b1, 32'h80, 1'b0);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        peek("hist_nt1", 32'h100, 1'b1, 32'h80);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        peek("hist_nt2", 32'h100, 1'b0, 32'h0);
        repeat (3) train(32'h100, 1'b1, 32'h80, 1'b0);
        peek("hist_t3", 32'h100, 1'b1, 32'h80);
        // No hit reached an edge, no repair: speculative history unchanged
        check("spek_hold", {26'd0, gecmis}, 32'h0);

        // Same-cycle read/write on 0x104 (index 2): bring counter to 01 with
        // the BTB entry valid. Committed history now 011110.
        train(32'h104, 1'b1, 32'h200, 1'b0);
        train(32'h104, 1'b0, 32'h0, 1'b0);
        peek("ayni_once", 32'h104, 1'b0, 32'h0);
        guncelle_gecerli = 1'b1; guncelle_atladi = 1'b1;
        guncelle_ps = 32'h104; guncelle_hedef_adresi = 32'h200;
        ps = 32'h104; ps_gecerli = 1'b1;
        #1;
        check("ayni_eski", {31'd0, atlar}, 32'h0);
        clk_step();     // hit shifts 0 into spek; committed becomes 111101
        guncelle_gecerli = 1'b0; guncelle_atladi = 1'b0; ps_gecerli = 1'b0;
        peek("ayni_yeni", 32'h104, 1'b1, 32'h200);
        check("ayni_gecmis", {26'd0, gecmis}, 32'h0);

        // History: three predicted-taken lookups shift in 1,1,1
        repeat (3) begin
            ps = 32'h100; ps_gecerli = 1'b1;
            #1;
            check("spek_atlar", {31'd0, atlar}, 32'h1);
            clk_step();
            ps_gecerli = 1'b0;
        end
        check("spek_111", {26'd0, gecmis}, 32'h07);

        // Repair: not-taken mispredict plus a simultaneous hit.
        // Committed 111101 -> 111010; the hit must not shift.
        ps = 32'h100; ps_gecerli = 1'b1;
        train(32'h104, 1'b0, 32'h0, 1'b1);
        ps_gecerli = 1'b0;
        check("onarim", {26'd0, gecmis}, 32'h3A);

        // Mispredict flag without update valid is ignored
        dallanma_hata = 1'b1;
        clk_step();
        dallanma_hata = 1'b0;
        check("hata_yoksay", {26'd0, gecmis}, 32'h3A);

        // Reset mid-operation together with a taken update
        rst = 1'b1;
        train(32'h100, 1'b1, 32'h80, 1'b0);
        rst = 1'b0;
        peek("orta_rst_100", 32'h100, 1'b0, 32'h0);
        peek("orta_rst_104", 32'h104, 1'b0, 32'h0);
        check("orta_rst_gecmis", {26'd0, gecmis}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
